tile_out_collector: RTL and testbench

Downstream drain stage for one systolic tile column. It consumes the tile's 136-bit accumulator output together with its valid/propagate/shift side-band, and detects result-drain cycles from propagate toggles. It rounds and shifts each drained result, saturates it to 32 bits and buffers it in a small FIFO. Results leave on a ready/valid port toward the accumulator SRAM writer. The tile cannot be stalled, so overflow drops results and flags them.

---
 rtl/tile_out_pkg.sv | 47 ++++
 rtl/tile_out_fifo.sv | 54 +++++
 rtl/tile_out_collector.sv | 91 +++++++++
 tb/tb_tile_out_collector.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_out_pkg.sv
// Shared widths, the buffered result entry and the round/saturate helper
// for the tile output drain path.
package tile_out_pkg;

  localparam int C_W     = 136;
  localparam int SHIFT_W = 6;
  localparam int OUT_W   = 32;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } entry_t;

  // Arithmetic right shift with round-half-toward-+inf, then clamp to OUT_W bits.
  // Shifting by sh-1 first exposes the rounding bit as the LSB of t.
  function automatic entry_t round_sat(input logic [C_W-1:0] c,
                                       input logic [SHIFT_W-1:0] sh);
    logic signed [C_W:0] ext;
    logic signed [C_W:0] t;
    logic signed [C_W:0] r;
    logic signed [C_W:0] max_v;
    logic signed [C_W:0] min_v;
    entry_t e;
    ext   = $signed({c[C_W-1], c});
    max_v = $signed({{(C_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
    min_v = $signed({{(C_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}});
    t     = ext;
    if (sh == '0) begin
      r = ext;
    end else begin
      t = ext >>> (sh - SHIFT_W'(1));
      r = (t >>> 1) + $signed({{C_W{1'b0}}, t[0]});
    end
    if (r > max_v) begin
      e.sat  = 1'b1;
      e.data = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (r < min_v) begin
      e.sat  = 1'b1;
      e.data = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      e.sat  = 1'b0;
      e.data = r[OUT_W-1:0];
    end
    return e;
  endfunction

endpackage

// File: rtl/tile_out_fifo.sv
// Small synchronous FIFO with extra pointer bit for full/empty; the head
// output holds its last value while the FIFO is empty.
module tile_out_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] wr_ptr_reg;
  logic [CW-1:0] rd_ptr_reg;
  logic [W-1:0]  hold_reg;
  logic          do_push;
  logic          do_pop;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is never reset; an empty FIFO presents hold_reg instead.
  assign head = empty ? hold_reg : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      hold_reg   <= '0;
    end else begin
      hold_reg <= head;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + CW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + CW'(1);
    end
  end

endmodule

// File: rtl/tile_out_collector.sv
// Drain stage for one systolic tile column: detects propagate toggles,
// rounds/saturates drained results and buffers them toward the SRAM writer.
module tile_out_collector
  import tile_out_pkg::*;
#(
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [C_W-1:0]     in_c,
  input  logic               in_valid,
  input  logic               in_propagate,
  input  logic [SHIFT_W-1:0] in_shift,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_sat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overflow,
  output logic [7:0]         drop_cnt,
  output logic [CNT_W-1:0]   count
);

  logic               prop_reg;
  logic               s1_v_reg;
  logic [C_W-1:0]     s1_c_reg;
  logic [SHIFT_W-1:0] s1_sh_reg;
  logic               capture;
  entry_t             s1_entry;
  entry_t             head;
  logic               full;
  logic               empty;
  logic               pop;
  logic               push;
  logic               drop;

  assign capture = in_valid && (in_propagate != prop_reg);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prop_reg  <= 1'b0;
      s1_v_reg  <= 1'b0;
      s1_c_reg  <= '0;
      s1_sh_reg <= '0;
    end else begin
      if (in_valid) prop_reg <= in_propagate;
      s1_v_reg <= capture;
      if (capture) begin
        s1_c_reg  <= in_c;
        s1_sh_reg <= in_shift;
      end
    end
  end

  assign s1_entry = round_sat(s1_c_reg, s1_sh_reg);

  // The tile cannot stall, so a result meeting a full FIFO with no pop is lost.
  assign pop  = out_valid && out_ready;
  assign push = s1_v_reg && (!full || pop);
  assign drop = s1_v_reg && full && !pop;

  tile_out_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (s1_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign out_valid = !empty;
  assign out_data  = head.data;
  assign out_sat   = head.sat;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tile_out_collector.sv
// Self-checking bench for tile_out_collector: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_tile_out_collector;
  import tile_out_pkg::*;

  localparam int DEPTH = 4;
  localparam logic signed [199:0] RMAX = 200'sd2147483647;
  localparam logic signed [199:0] RMIN = -200'sd2147483648;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [135:0] in_c = '0;
  logic         in_valid = 1'b0;
  logic         in_propagate = 1'b0;
  logic [5:0]   in_shift = '0;
  logic [31:0]  out_data;
  logic         out_sat;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         overflow;
  logic [7:0]   drop_cnt;
  logic [2:0]   count;

  int total = 0;
  int bad = 0;

  // reference model state
  bit                   m_prop;
  bit                   m_s1_v;
  logic signed [135:0]  m_s1_c;
  int                   m_s1_sh;
  logic [32:0]          q[$];
  bit                   m_ovf;
  int                   m_drop;

  tile_out_collector #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_c         (in_c),
    .in_valid     (in_valid),
    .in_propagate (in_propagate),
    .in_shift     (in_shift),
    .out_data     (out_data),
    .out_sat      (out_sat),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .count        (count)
  );

  always #5 clock = ~clock;

  // round half up == floor((c + 2^(sh-1)) / 2^sh), then clamp
  function automatic logic [32:0] ref_result(input logic signed [135:0] c, input int sh);
    logic signed [199:0] w;
    w = c;
    if (sh > 0) w = w + (200'sd1 <<< (sh - 1));
    w = w >>> sh;
    if (w > RMAX) return {1'b1, 32'h7FFF_FFFF};
    if (w < RMIN) return {1'b1, 32'h8000_0000};
    return {1'b0, w[31:0]};
  endfunction

  function automatic logic signed [135:0] rand_c();
    logic signed [63:0]  r;
    logic signed [135:0] c;
    r = {$urandom, $urandom};
    c = r;
    c = c >>> $urandom_range(0, 40);
    if ($urandom_range(0, 7) == 0) c = c <<< 60;
    return c;
  endfunction

  function automatic int rand_sh();
    if ($urandom_range(0, 9) == 0) return 63;
    return $urandom_range(0, 24);
  endfunction

  task automatic model_reset();
    m_prop = 0; m_s1_v = 0; m_s1_c = '0; m_s1_sh = 0;
    q.delete(); m_ovf = 0; m_drop = 0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then sample #1 later.
  task automatic tick(input bit v, input bit p, input logic signed [135:0] c,
                      input int sh, input bit rdy);
    logic [32:0] res;
    in_valid = v; in_propagate = p; in_c = c; in_shift = sh[5:0]; out_ready = rdy;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (m_s1_v) begin
      res = ref_result(m_s1_c, m_s1_sh);
      if (q.size() < DEPTH) q.push_back(res);
      else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    m_s1_v = v && (p != m_prop);
    if (m_s1_v) begin m_s1_c = c; m_s1_sh = sh; end
    if (v) m_prop = p;
    @(posedge clock); #1;
  endtask

  task automatic cap(input logic signed [135:0] c, input int sh, input bit rdy);
    tick(1'b1, !m_prop, c, sh, rdy);
  endtask

  task automatic idle(input bit rdy);
    tick(1'b0, m_prop, '0, 0, rdy);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (out_data !== 32'd0 || out_sat !== 1'b0) begin bad++; $display("FAIL reset_data got=%h/%0b want=0/0", out_data, out_sat); end
    total++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_ovf got=%0b/%0d want=0/0", overflow, drop_cnt); end
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_toggle();
    logic signed [135:0] c11, c22;
    c11 = 136'sd11; c22 = 136'sd22;
    tick(1, 0, '0, 0, 0);
    tick(1, 0, '0, 0, 0);
    tick(1, 1, c11, 0, 0);
    tick(1, 1, '0, 0, 0);
    tick(1, 0, c22, 0, 0);
    tick(0, 1, 136'sd99, 0, 0);
    tick(0, 0, 136'sd98, 0, 0);
    tick(0, 1, 136'sd97, 0, 0);
    idle(0);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL toggle_captures got=%0d want=2", count); end
    total++; if (out_data !== 32'd11) begin bad++; $display("FAIL toggle_first got=%0d want=11", out_data); end
    idle(1);
    total++; if (out_data !== 32'd22 || out_valid !== 1'b1) begin bad++; $display("FAIL toggle_second got=%0d/%0b want=22/1", out_data, out_valid); end
    idle(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL toggle_empty got=%0b want=0", out_valid); end
  endtask

  task automatic test_rounding();
    logic signed [135:0] cs[3];
    int shs[3];
    int exp_d[3];
    cs[0] = 136'sd1000;  shs[0] = 4; exp_d[0] = 63;
    cs[1] = -136'sd1000; shs[1] = 4; exp_d[1] = -62;
    cs[2] = 136'sd5;     shs[2] = 0; exp_d[2] = 5;
    for (int i = 0; i < 3; i++) begin
      cap(cs[i], shs[i], 1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL round_early[%0d] got=%0b want=0", i, out_valid); end
      idle(1);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_sat !== 1'b0) begin
        bad++; $display("FAIL round[%0d] got=%0d/%0b/%0b want=%0d/0/1", i, $signed(out_data), out_sat, out_valid, exp_d[i]);
      end
      $display("round c=%0d sh=%0d -> %0d", cs[i], shs[i], $signed(out_data));
      idle(1);
    end
  endtask

  task automatic test_saturation();
    logic signed [135:0] cs[3];
    int shs[3];
    logic [31:0] exp_d[3];
    cs[0] = 136'sd1 <<< 40;    shs[0] = 0; exp_d[0] = 32'h7FFF_FFFF;
    cs[1] = -(136'sd1 <<< 40); shs[1] = 0; exp_d[1] = 32'h8000_0000;
    cs[2] = 136'sd1 <<< 40;    shs[2] = 9; exp_d[2] = 32'h7FFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      cap(cs[i], shs[i], 1);
      idle(1);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_sat !== 1'b1) begin
        bad++; $display("FAIL sat[%0d] got=%h/%0b/%0b want=%h/1/1", i, out_data, out_sat, out_valid, exp_d[i]);
      end
      $display("sat case %0d sh=%0d -> %h sat=%0b", i, shs[i], out_data, out_sat);
      idle(1);
    end
  endtask

  task automatic test_overflow();
    logic signed [135:0] c;
    int sh;
    logic [32:0] exp_v[4];
    for (int i = 0; i < 6; i++) begin
      c = rand_c(); sh = rand_sh();
      if (i < 4) exp_v[i] = ref_result(c, sh);
      cap(c, sh, 0);
    end
    idle(0);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL ovf_drops got=%0d want=2", drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_sat, out_data} !== exp_v[i]) begin bad++; $display("FAIL ovf_order[%0d] got=%h want=%h", i, {out_sat, out_data}, exp_v[i]); end
      idle(1);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0b want=0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    logic signed [135:0] c;
    int sh;
    logic [32:0] exp_v[5];
    for (int i = 0; i < 5; i++) begin
      c = rand_c(); sh = rand_sh();
      exp_v[i] = ref_result(c, sh);
      cap(c, sh, 0);
    end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fpp_full got=%0d want=4", count); end
    idle(1);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fpp_count got=%0d want=4", count); end
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL fpp_drops got=%0d want=2", drop_cnt); end
    for (int i = 1; i < 5; i++) begin
      total++;
      if ({out_sat, out_data} !== exp_v[i]) begin bad++; $display("FAIL fpp_order[%0d] got=%h want=%h", i, {out_sat, out_data}, exp_v[i]); end
      idle(1);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cap(rand_c(), rand_sh(), 0);
    in_valid = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0b want=0", out_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_mid_count got=%0d want=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_mid_ovf got=%0b want=0", overflow); end
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_stale[%0d] got=%0b want=0", i, out_valid); end
    end
    cap(136'sd77, 1, 1);
    idle(1);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd39) begin bad++; $display("FAIL rst_mid_first got=%0d/%0b want=39/1", out_data, out_valid); end
    idle(1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tick($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, rand_c(), rand_sh(),
           $urandom_range(0, 9) < 6);
      total++;
      if (out_valid !== (q.size() > 0) || count !== 3'(q.size())) begin
        bad++; $display("FAIL rnd_occ cyc=%0d got=%0b/%0d want=%0b/%0d", n, out_valid, count, q.size() > 0, q.size());
      end
      total++;
      if (overflow !== m_ovf || drop_cnt !== 8'(m_drop)) begin
        bad++; $display("FAIL rnd_drop cyc=%0d got=%0b/%0d want=%0b/%0d", n, overflow, drop_cnt, m_ovf, m_drop);
      end
      if (q.size() > 0) begin
        total++;
        if ({out_sat, out_data} !== q[0]) begin
          bad++; $display("FAIL rnd_head cyc=%0d got=%h want=%h", n, {out_sat, out_data}, q[0]);
        end
      end
    end
    $display("random run: drops=%0d", m_drop);
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_rounding();
    test_saturation();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
